// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU, the instruction decoder and the ALU
// arbiter: datapath/command widths, ALU command encodings, the packed
// operation record and the arbiter state type.
// No ports (package).
package alu_pkg;

  localparam int CW = 5;
  localparam int DW = 8;

  // ALU command encodings. The arbiter only passes these through; the
  // ALU and the decoder give them meaning.
  localparam logic [CW-1:0] CMD_NOP = 5'b00000;
  localparam logic [CW-1:0] CMD_ADD = 5'b00001;
  localparam logic [CW-1:0] CMD_SUB = 5'b00010;
  localparam logic [CW-1:0] CMD_AND = 5'b00011;
  localparam logic [CW-1:0] CMD_OR  = 5'b00100;
  localparam logic [CW-1:0] CMD_XOR = 5'b00101;
  localparam logic [CW-1:0] CMD_BEQ = 5'b00110;
  localparam logic [CW-1:0] CMD_BNE = 5'b00111;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   i_req  [1:0] request vector
//   i_last       index of the requester granted most recently
//   i_en         grant enable; no grant is produced while low
//   o_gnt  [1:0] one-hot grant (all zero when nothing is picked)
module rr_pick2
  import alu_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // On contention the requester that did not win last time goes next,
  // which gives strict alternation when both keep requesting.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between the instruction datapath
// (requester 0) and an auxiliary unit (requester 1). Accepts at most one
// operation per cycle, registers the ALU result/branch flag and hands it
// back to the owning requester with a valid/ready handshake.
// Ports:
//   clk, reset                 clock, async active-high reset
//   req[1:0]                   per-requester request
//   cmd0/a0/b0, cmd1/a1/b1     operation of requester 0 / 1
//   gnt[1:0]                   one-hot combinational grant (accept cycle)
//   alu_cmd/alu_a/alu_b        operands driven to the ALU
//   alu_rslt/alu_do_branch     combinational ALU outputs
//   rsp_valid[1:0]             one-hot response pending per requester
//   rsp_rslt/rsp_branch        registered response payload
//   rsp_ready[1:0]             per-requester response consume
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW         = alu_pkg::DW,
  parameter int CW         = alu_pkg::CW,
  parameter int PRIO_RESET = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [CW-1:0] cmd0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [CW-1:0] cmd1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic [1:0]    gnt,
  output logic [CW-1:0] alu_cmd,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_do_branch,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rslt,
  output logic          rsp_branch,
  input  logic [1:0]    rsp_ready
);

  // Seeding last with the other requester makes PRIO_RESET win the first
  // contended pick.
  localparam logic LAST_RESET = (PRIO_RESET == 0) ? 1'b1 : 1'b0;

  arb_state_t    r_state;
  logic          r_own;
  logic          r_last;
  logic [DW-1:0] r_rslt;
  logic          r_branch;

  logic          w_canAccept;
  logic          w_pickEn;
  logic [1:0]    w_gnt;

  // A new op may be accepted when nothing is held, or when the held
  // response is being consumed by its owner in this same cycle. Only the
  // owner's ready bit counts. Reset blocks grants asynchronously.
  assign w_canAccept = (r_state == IDLE) || rsp_ready[r_own];
  assign w_pickEn    = w_canAccept && !reset;

  rr_pick2 u_pick (
    .i_req  (req),
    .i_last (r_last),
    .i_en   (w_pickEn),
    .o_gnt  (w_gnt)
  );

  assign gnt = w_gnt;

  // Steer the granted requester's operation to the ALU; with no grant the
  // ALU sees a NOP with zero operands so it never computes on stale data.
  always_comb begin
    alu_cmd = CMD_NOP;
    alu_a   = '0;
    alu_b   = '0;
    if (w_gnt[0]) begin
      alu_cmd = cmd0;
      alu_a   = a0;
      alu_b   = b0;
    end else if (w_gnt[1]) begin
      alu_cmd = cmd1;
      alu_a   = a1;
      alu_b   = b1;
    end
  end

  // Response register and FSM. A grant always (re)loads the response,
  // which is what allows consume-and-accept in one cycle. Without a grant
  // the response is released once the owner takes it, else held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_own    <= 1'b0;
      r_last   <= LAST_RESET;
      r_rslt   <= '0;
      r_branch <= 1'b0;
    end else if (w_gnt != 2'b00) begin
      r_state  <= RESP;
      r_own    <= w_gnt[1];
      r_last   <= w_gnt[1];
      r_rslt   <= alu_rslt;
      r_branch <= alu_do_branch;
    end else if ((r_state == RESP) && rsp_ready[r_own]) begin
      r_state  <= IDLE;
    end
  end

  assign rsp_valid  = (r_state == RESP) ? (r_own ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rslt   = r_rslt;
  assign rsp_branch = r_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a table of directed vectors, a
// hand-written reset-mid-operation sequence, then randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic          clock;
  logic          reset;
  logic [1:0]    req;
  logic [CW-1:0] cmd0, cmd1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [1:0]    gnt;
  logic [CW-1:0] aluCmd;
  logic [DW-1:0] aluA, aluB;
  logic [DW-1:0] aluRslt;
  logic          aluBranch;
  logic [1:0]    rspValid;
  logic [DW-1:0] rspRslt;
  logic          rspBranch;
  logic [1:0]    rspReady;

  int checkCount = 0;
  int passCount  = 0;

  alu_arbiter #(.DW(DW), .CW(CW), .PRIO_RESET(0)) dut (
    .clk           (clock),
    .reset         (reset),
    .req           (req),
    .cmd0          (cmd0),
    .a0            (a0),
    .b0            (b0),
    .cmd1          (cmd1),
    .a1            (a1),
    .b1            (b1),
    .gnt           (gnt),
    .alu_cmd       (aluCmd),
    .alu_a         (aluA),
    .alu_b         (aluB),
    .alu_rslt      (aluRslt),
    .alu_do_branch (aluBranch),
    .rsp_valid     (rspValid),
    .rsp_rslt      (rspRslt),
    .rsp_branch    (rspBranch),
    .rsp_ready     (rspReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU: {branch, result}
  function automatic logic [DW:0] aluEval(input logic [CW-1:0] c,
                                          input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    logic [DW-1:0] r;
    logic br;
    r  = '0;
    br = 1'b0;
    case (c)
      CMD_ADD: r = x + y;
      CMD_SUB: r = x - y;
      CMD_AND: r = x & y;
      CMD_OR:  r = x | y;
      CMD_XOR: r = x ^ y;
      CMD_BEQ: begin r = x - y; br = (x == y); end
      CMD_BNE: begin r = x - y; br = (x != y); end
      default: begin r = '0; br = 1'b0; end
    endcase
    return {br, r};
  endfunction

  always_comb {aluBranch, aluRslt} = aluEval(aluCmd, aluA, aluB);

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] rdy,
                               input logic [CW-1:0] c0, input logic [DW-1:0] x0,
                               input logic [DW-1:0] y0, input logic [CW-1:0] c1,
                               input logic [DW-1:0] x1, input logic [DW-1:0] y1);
    req = r; rspReady = rdy;
    cmd0 = c0; a0 = x0; b0 = y0;
    cmd1 = c1; a1 = x1; b1 = y1;
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    ready;
    logic [CW-1:0] cmd0;
    logic [DW-1:0] a0, b0;
    logic [CW-1:0] cmd1;
    logic [DW-1:0] a1, b1;
    logic [1:0]    expGnt;
    logic [1:0]    expValid;
    logic [DW-1:0] expRslt;
    logic          expBranch;
  } vec_t;

  vec_t vecs[13];

  // Model state for the random phase
  logic          mValid, mOwn, mLast, mBranch;
  logic [DW-1:0] mRslt;
  logic          pend[2];
  logic [CW-1:0] opCmd[2];
  logic [DW-1:0] opA[2], opB[2];

  initial begin
    logic [CW-1:0] eCmd;
    logic [DW-1:0] eA, eB;
    logic [DW:0]   ev;
    logic [1:0]    eGnt;
    logic          canAcc;

    // contention, last=1 after reset -> 01,10,01,10
    vecs[0]  = '{2'b11, 2'b11, CMD_ADD, 8'h01, 8'h02, CMD_SUB, 8'h09, 8'h04, 2'b01, 2'b01, 8'h03, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, CMD_ADD, 8'h10, 8'h20, CMD_SUB, 8'h09, 8'h04, 2'b10, 2'b10, 8'h05, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, CMD_ADD, 8'h10, 8'h20, CMD_XOR, 8'hFF, 8'h0F, 2'b01, 2'b01, 8'h30, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, CMD_AND, 8'hF3, 8'h3C, CMD_XOR, 8'hFF, 8'h0F, 2'b10, 2'b10, 8'hF0, 1'b0};
    // single op
    vecs[4]  = '{2'b01, 2'b11, CMD_ADD, 8'h05, 8'h03, CMD_NOP, 8'h00, 8'h00, 2'b01, 2'b01, 8'h08, 1'b0};
    // backpressure: BEQ taken, owner 1 not ready, foreign ready[0] ignored
    vecs[5]  = '{2'b10, 2'b11, CMD_NOP, 8'h00, 8'h00, CMD_BEQ, 8'h2A, 8'h2A, 2'b10, 2'b10, 8'h00, 1'b1};
    vecs[6]  = '{2'b01, 2'b01, CMD_SUB, 8'h10, 8'h01, CMD_NOP, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 1'b1};
    vecs[7]  = '{2'b01, 2'b01, CMD_SUB, 8'h10, 8'h01, CMD_NOP, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 1'b1};
    vecs[8]  = '{2'b01, 2'b01, CMD_SUB, 8'h10, 8'h01, CMD_NOP, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 1'b1};
    // ready[1] rises: grant same cycle, then back-to-back on requester 0
    vecs[9]  = '{2'b01, 2'b10, CMD_SUB, 8'h10, 8'h01, CMD_NOP, 8'h00, 8'h00, 2'b01, 2'b01, 8'h0F, 1'b0};
    vecs[10] = '{2'b01, 2'b11, CMD_OR,  8'hF0, 8'h0F, CMD_NOP, 8'h00, 8'h00, 2'b01, 2'b01, 8'hFF, 1'b0};
    // owner 0, only foreign ready high: held, no grant
    vecs[11] = '{2'b01, 2'b10, CMD_ADD, 8'h01, 8'h01, CMD_NOP, 8'h00, 8'h00, 2'b00, 2'b01, 8'hFF, 1'b0};
    // owner consumes, nothing new
    vecs[12] = '{2'b00, 2'b01, CMD_NOP, 8'h00, 8'h00, CMD_NOP, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};

    // Reset state, with requests present
    applyStimulus(2'b11, 2'b11, CMD_ADD, 8'h01, 8'h01, CMD_ADD, 8'h02, 8'h02);
    reset = 1'b1;
    #12;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_alu_cmd", 32'(aluCmd), 32'(CMD_NOP));
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset_rsp_rslt", 32'(rspRslt), 32'h0);
    checkOutput("reset_rsp_branch", 32'(rspBranch), 32'h0);
    applyStimulus(2'b00, 2'b00, CMD_NOP, 8'h00, 8'h00, CMD_NOP, 8'h00, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].req, vecs[i].ready, vecs[i].cmd0, vecs[i].a0, vecs[i].b0,
                    vecs[i].cmd1, vecs[i].a1, vecs[i].b1);
      #1;
      checkOutput($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].expGnt));
      eCmd = CMD_NOP; eA = '0; eB = '0;
      if (vecs[i].expGnt == 2'b01) begin eCmd = vecs[i].cmd0; eA = vecs[i].a0; eB = vecs[i].b0; end
      if (vecs[i].expGnt == 2'b10) begin eCmd = vecs[i].cmd1; eA = vecs[i].a1; eB = vecs[i].b1; end
      checkOutput($sformatf("vec%0d_alu", i), {11'h0, aluCmd, aluA, aluB}, {11'h0, eCmd, eA, eB});
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(rspValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid != 2'b00) begin
        checkOutput($sformatf("vec%0d_rslt", i), 32'(rspRslt), 32'(vecs[i].expRslt));
        checkOutput($sformatf("vec%0d_branch", i), 32'(rspBranch), 32'(vecs[i].expBranch));
      end
    end

    // Reset mid-operation: response held with ready low, then reset
    applyStimulus(2'b01, 2'b00, CMD_ADD, 8'h05, 8'h03, CMD_NOP, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    checkOutput("midop_valid_before", 32'(rspValid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midop_valid_cleared", 32'(rspValid), 32'h0);
    checkOutput("midop_rslt_cleared", 32'(rspRslt), 32'h0);
    checkOutput("midop_gnt_in_reset", 32'(gnt), 32'h0);
    applyStimulus(2'b11, 2'b11, CMD_SUB, 8'h09, 8'h02, CMD_ADD, 8'h40, 8'h01);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_gnt_prio", 32'(gnt), 32'h1);
    @(posedge clock);
    #1;
    checkOutput("post_reset_valid", 32'(rspValid), 32'h1);
    checkOutput("post_reset_rslt", 32'(rspRslt), 32'h07);

    // Randomized traffic against the transaction model
    applyStimulus(2'b00, 2'b00, CMD_NOP, 8'h00, 8'h00, CMD_NOP, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mValid = 1'b0; mOwn = 1'b0; mLast = 1'b1; mRslt = '0; mBranch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; opCmd[i] = CMD_NOP; opA[i] = '0; opB[i] = '0;
    end
    @(posedge clock);
    #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && ($urandom % 16 == 0)) pend[i] = 1'b0;
        else if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i]  = 1'b1;
          opCmd[i] = 5'($urandom_range(1, 7));
          opA[i]   = 8'($urandom);
          opB[i]   = ($urandom % 4 == 0) ? opA[i] : 8'($urandom);
        end
      end
      applyStimulus({pend[1], pend[0]},
                    {1'($urandom % 4 != 0), 1'($urandom % 4 != 0)},
                    opCmd[0], opA[0], opB[0], opCmd[1], opA[1], opB[1]);
      #1;
      canAcc = !mValid || rspReady[mOwn];
      eGnt = 2'b00;
      if (canAcc) begin
        if (pend[0] && pend[1]) eGnt = mLast ? 2'b01 : 2'b10;
        else if (pend[0]) eGnt = 2'b01;
        else if (pend[1]) eGnt = 2'b10;
      end
      checkOutput("rand_gnt", 32'(gnt), 32'(eGnt));
      eCmd = CMD_NOP; eA = '0; eB = '0;
      if (eGnt == 2'b01) begin eCmd = opCmd[0]; eA = opA[0]; eB = opB[0]; end
      if (eGnt == 2'b10) begin eCmd = opCmd[1]; eA = opA[1]; eB = opB[1]; end
      checkOutput("rand_alu", {11'h0, aluCmd, aluA, aluB}, {11'h0, eCmd, eA, eB});
      if (eGnt != 2'b00) begin
        ev = aluEval(eCmd, eA, eB);
        mValid  = 1'b1;
        mOwn    = eGnt[1];
        mLast   = eGnt[1];
        mRslt   = ev[DW-1:0];
        mBranch = ev[DW];
        pend[eGnt[1]] = 1'b0;
      end else if (mValid && rspReady[mOwn]) begin
        mValid = 1'b0;
      end
      @(posedge clock);
      #1;
      checkOutput("rand_valid", 32'(rspValid),
                  32'(mValid ? (mOwn ? 2'b10 : 2'b01) : 2'b00));
      if (mValid) begin
        checkOutput("rand_rslt", 32'(rspRslt), 32'(mRslt));
        checkOutput("rand_branch", 32'(rspBranch), 32'(mBranch));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares the single combinational ALU between the main instruction datapath (requester 0) and an auxiliary unit (requester 1, e.g. a lookup/checksum engine). It accepts one operation per cycle, drives the ALU operands, registers the result and branch flag, and returns them to the owning requester with a valid/ready handshake. It sits between the requesters and the ALU instance in the top level.

## Interface
Parameters:
- `DW`, 8: data path width.
- `CW`, 5: ALU command width.
- `PRIO_RESET`, 0: requester that wins a simultaneous request in the first contended cycle after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  2  per-requester request; held high with stable operands until granted.
- `cmd0`, `cmd1`  in  CW  ALU command of requester 0 / 1.
- `a0`, `b0`, `a1`, `b1`  in  DW  operands of requester 0 / 1.
- `gnt`  out  2  one-hot grant, combinational; the request is accepted in the cycle `gnt[i]` is high.
- `alu_cmd`  out  CW  command to the ALU.
- `alu_a`, `alu_b`  out  DW  operands to the ALU.
- `alu_rslt`  in  DW  ALU result, combinational from `alu_cmd`/`alu_a`/`alu_b`.
- `alu_do_branch`  in  1  ALU branch flag.
- `rsp_valid`  out  2  one-hot; response pending for requester i.
- `rsp_rslt`  out  DW  registered result.
- `rsp_branch`  out  1  registered branch flag.
- `rsp_ready`  in  2  requester i consumes its response.

## Operation
- FSM with two states. IDLE: no response held. RESP: response held for owner `own`.
- Grant eligibility (`can_accept`): state IDLE, or state RESP and `rsp_ready[own]` is high this cycle.
- Picker: if `can_accept` is high and exactly one `req` bit is set, grant it. If both are set, grant the requester other than `last`. After reset, `last` = !`PRIO_RESET`.
- On a grant to requester i: `alu_cmd/a/b` = `cmd_i/a_i/b_i`. At the edge, latch `alu_rslt` and `alu_do_branch`, set `own` = i and `last` = i, and go to or stay in RESP.
- No grant: `alu_cmd` = NOP (5'b00000), `alu_a` = `alu_b` = 0; all ALU commands are treated identically, with no decoding beyond passthrough.
- RESP with `rsp_ready[own]` high and no new grant: go to IDLE and clear `rsp_valid`.
- RESP with `rsp_ready[own]` low: hold response and ALU outputs at NOP, no grants (backpressure).
- `rsp_ready` of a non-owner is ignored. A `req` that is not granted is not dropped; it stays pending.
- `gnt` never asserts during reset. A requester that deasserts `req` before grant withdraws the request.

## Timing
- Reset values: `rsp_valid` = 2'b00, `rsp_rslt` = 0, `rsp_branch` = 0, state IDLE, `own` = 0, `last` = !`PRIO_RESET`. `gnt` = 0 and ALU outputs at NOP while `reset` is high.
- Latency: a grant in cycle N gives `rsp_valid[i]` high in cycle N+1.
- Throughput: 1 op/cycle when the owner holds `rsp_ready` high. Accept and consume in the same cycle is legal, including the same requester back-to-back.
- Reset asserted mid-operation: pending response is discarded immediately (asynchronous); no response is ever delivered for it.
- Both requesters active continuously with ready high: grants alternate 0,1,0,1…
- All arithmetic and width behaviour belongs to the ALU. The arbiter neither truncates nor extends data.

## Structure
- Shared package `alu_pkg`:
  - `CW`/`DW` constants.
  - ALU command encodings (NOP, ADD, SUB, BEQ, …), also used by the ALU and decoder.
  - `typedef struct packed {cmd, a, b} alu_op_t`.
  - State enum `arb_state_t {IDLE, RESP}`.
- One sub-module: `rr_pick2`, a combinational 2-way round-robin picker (inputs `req`, `last`, `en`; output one-hot `gnt`), instantiated once.

## Test plan
- Single op: after reset, `req`=01, `cmd0`=ADD, `a0`=8'h05, `b0`=8'h03, `rsp_ready`=11 -> `gnt`=01 same cycle; next cycle `rsp_valid`=01, `rsp_rslt`=8'h08, `rsp_branch`=0.
- Contention: `req`=11 held 4 cycles, `PRIO_RESET`=0, ready high -> `gnt` sequence 01,10,01,10; results correspond to the granted operands.
- Backpressure: requester 1 granted BEQ with 8'h2A/8'h2A, `rsp_ready[1]`=0 for 3 cycles while `req`=01 -> `rsp_valid`=10, `rsp_branch`=1 held, `gnt`=00, ALU at NOP. When `rsp_ready[1]` rises, `gnt`=01 that same cycle.
- Back-to-back: requester 0 issues SUB 8'h10-8'h01 then OR 8'hF0|8'h0F with ready high -> consecutive `rsp_rslt` 8'h0F, 8'hFF, with `rsp_valid[0]` continuously high.
- Reset mid-op: assert `reset` while `rsp_valid`=01 and ready low -> `rsp_valid`=00 and `rsp_rslt`=0 immediately. After release with `req`=11, the first grant goes to `PRIO_RESET`.
- Ignored foreign ready: `own`=0, `rsp_ready`=10 -> response held, no grant issued.
